// File: rtl/t0_tpdu_sequencer.sv
// T=0 TPDU sequencer: sends the command header, follows procedure bytes,
// moves data to/from the master UART and collects SW1/SW2.
module t0_tpdu_sequencer #(
    parameter int unsigned WWT_CYCLES = 9600 * 372
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       start,
    input  logic [7:0] cla,
    input  logic [7:0] ins,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    input  logic       isWrite,
    input  logic [7:0] txByte,
    input  logic       txValid,
    output logic       txReady,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       busy,
    output logic       done,
    output logic [7:0] sw1,
    output logic [7:0] sw2,
    output logic [1:0] errCode,
    output logic [7:0] masterDataIn,
    output logic       masterNWe,
    input  logic [7:0] masterDataOut,
    output logic       masterNCs,
    input  logic [7:0] masterStatus
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PROC, S_DATA_TX, S_DATA_RX, S_SW2, S_DONE
    } state_e;

    localparam logic [31:0] TMO_LAST = WWT_CYCLES - 1;

    state_e          state_q, state_d;
    logic [4:0][7:0] hdr_q, hdr_d;
    logic            isWrite_q, isWrite_d;
    logic            single_q, single_d;
    logic [8:0]      rem_q, rem_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     timer_q, timer_d;
    logic            nWe_q, nWe_d;
    logic            nCs_q, nCs_d;
    logic            rdGap_q, rdGap_d;
    logic [7:0]      dataIn_q, dataIn_d;
    logic [7:0]      rxByte_q, rxByte_d;
    logic            rxValid_q, rxValid_d;
    logic [7:0]      sw1_q, sw1_d;
    logic [7:0]      sw2_q, sw2_d;
    logic [1:0]      err_q, err_d;

    logic       txPending, lineErrIn, bufFull;
    logic       waitSt, lineErr, canWrite;
    logic       hdrWr, txAcc, rdFire, rdReq, tmo, lastXfer;
    logic [7:0] insQ;
    logic [8:0] remDec;
    logic       unused_status;

    function automatic logic isWait(input state_e s);
        return (s == S_PROC) || (s == S_DATA_RX) || (s == S_SW2);
    endfunction

    assign txPending     = masterStatus[6];
    assign lineErrIn     = masterStatus[2] | masterStatus[1];
    assign bufFull       = masterStatus[0];
    assign unused_status = ^{masterStatus[7], masterStatus[5:3]};

    assign insQ     = hdr_q[1];
    assign waitSt   = isWait(state_q);
    assign lineErr  = (state_q != S_IDLE) && (state_q != S_DONE) && lineErrIn;
    assign canWrite = !txPending && nWe_q && !lineErr;
    assign hdrWr    = (state_q == S_HDR) && canWrite;
    assign txAcc    = (state_q == S_DATA_TX) && canWrite && txValid;
    assign rdFire   = waitSt && !nCs_q && !lineErr;
    assign rdReq    = waitSt && nCs_q && !rdGap_q && bufFull && !lineErr;
    assign tmo      = waitSt && nCs_q && !rdReq && (timer_q >= TMO_LAST);
    assign remDec   = (rem_q == 9'd0) ? 9'd0 : rem_q - 9'd1;
    assign lastXfer = single_q || (rem_q <= 9'd1);

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath and master strobe registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hdr_q     <= '0;
            isWrite_q <= 1'b0;
            single_q  <= 1'b0;
            rem_q     <= 9'd0;
            idx_q     <= 3'd0;
            timer_q   <= 32'd0;
            nWe_q     <= 1'b1;
            nCs_q     <= 1'b1;
            rdGap_q   <= 1'b0;
            dataIn_q  <= 8'h00;
            rxByte_q  <= 8'h00;
            rxValid_q <= 1'b0;
            sw1_q     <= 8'h00;
            sw2_q     <= 8'h00;
            err_q     <= 2'd0;
        end else begin
            hdr_q     <= hdr_d;
            isWrite_q <= isWrite_d;
            single_q  <= single_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            nWe_q     <= nWe_d;
            nCs_q     <= nCs_d;
            rdGap_q   <= rdGap_d;
            dataIn_q  <= dataIn_d;
            rxByte_q  <= rxByte_d;
            rxValid_q <= rxValid_d;
            sw1_q     <= sw1_d;
            sw2_q     <= sw2_d;
            err_q     <= err_d;
        end
    end

    // Next state: procedure-byte decode, counters, strobe requests
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        isWrite_d = isWrite_q;
        single_d  = single_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        sw1_d     = sw1_q;
        sw2_d     = sw2_q;
        err_d     = err_q;
        rxByte_d  = rxByte_q;
        rxValid_d = 1'b0;
        dataIn_d  = dataIn_q;
        nWe_d     = !(hdrWr || txAcc);
        nCs_d     = !rdReq;
        rdGap_d   = !nCs_q;

        if (hdrWr)      dataIn_d = hdr_q[idx_q];
        else if (txAcc) dataIn_d = txByte;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    hdr_d     = {p3, p2, p1, ins, cla};
                    isWrite_d = isWrite;
                    rem_d     = (!isWrite && p3 == 8'h00) ? 9'd256 : {1'b0, p3};
                    idx_d     = 3'd0;
                    single_d  = 1'b0;
                    sw1_d     = 8'h00;
                    sw2_d     = 8'h00;
                    err_d     = 2'd0;
                end
            end
            S_HDR: begin
                if (hdrWr) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd4) state_d = S_PROC;
                end
            end
            S_PROC: begin
                if (rdFire && masterDataOut != 8'h60) begin
                    if (masterDataOut == insQ || masterDataOut == ~insQ) begin
                        single_d = (masterDataOut != insQ);
                        if (rem_q != 9'd0)
                            state_d = isWrite_q ? S_DATA_TX : S_DATA_RX;
                    end else if (masterDataOut[7:4] == 4'h6 ||
                                 masterDataOut[7:4] == 4'h9) begin
                        sw1_d   = masterDataOut;
                        state_d = S_SW2;
                    end else begin
                        err_d   = 2'd2;
                        state_d = S_DONE;
                    end
                end
            end
            S_DATA_TX: begin
                if (txAcc) begin
                    rem_d = remDec;
                    if (lastXfer) state_d = S_PROC;
                end
            end
            S_DATA_RX: begin
                if (rdFire) begin
                    rxByte_d  = masterDataOut;
                    rxValid_d = 1'b1;
                    rem_d     = remDec;
                    if (lastXfer) state_d = S_PROC;
                end
            end
            S_SW2: begin
                if (rdFire) begin
                    sw2_d   = masterDataOut;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (tmo) begin
            err_d   = 2'd1;
            state_d = S_DONE;
        end
        if (lineErr) begin
            err_d   = 2'd3;
            state_d = S_DONE;
        end

        if ((state_d != state_q && isWait(state_d)) || rdFire)
            timer_d = 32'd0;
        else if (waitSt)
            timer_d = timer_q + 32'd1;
        else
            timer_d = 32'd0;
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy         = (state_q != S_IDLE) && (state_q != S_DONE);
        done         = (state_q == S_DONE);
        txReady      = (state_q == S_DATA_TX) && canWrite;
        masterNWe    = nWe_q;
        masterNCs    = nCs_q;
        masterDataIn = dataIn_q;
        rxByte       = rxByte_q;
        rxValid      = rxValid_q;
        sw1          = sw1_q;
        sw2          = sw2_q;
        errCode      = err_q;
    end

endmodule

// File: tb/tb_t0_tpdu_sequencer.sv
// Bench for t0_tpdu_sequencer: card/UART model plus scoreboarded
// master writes and received bytes.
`timescale 1ns/1ps
module tb_t0_tpdu_sequencer;

    localparam int WWT = 40;

    logic       clk = 1'b0;
    logic       nReset, start, isWrite;
    logic [7:0] cla, ins, p1, p2, p3;
    logic [7:0] txByte;
    logic       txValid, txReady;
    logic [7:0] rxByte;
    logic       rxValid, busy, done;
    logic [7:0] sw1, sw2;
    logic [1:0] errCode;
    logic [7:0] masterDataIn;
    logic       masterNWe;
    logic [7:0] masterDataOut;
    logic       masterNCs;
    logic [7:0] masterStatus;

    always #5 clk = ~clk;

    t0_tpdu_sequencer #(.WWT_CYCLES(WWT)) dut (
        .clk(clk), .nReset(nReset), .start(start),
        .cla(cla), .ins(ins), .p1(p1), .p2(p2), .p3(p3),
        .isWrite(isWrite), .txByte(txByte), .txValid(txValid),
        .txReady(txReady), .rxByte(rxByte), .rxValid(rxValid),
        .busy(busy), .done(done), .sw1(sw1), .sw2(sw2),
        .errCode(errCode), .masterDataIn(masterDataIn),
        .masterNWe(masterNWe), .masterDataOut(masterDataOut),
        .masterNCs(masterNCs), .masterStatus(masterStatus)
    );

    typedef struct packed {
        logic [7:0]  cla, ins, p1, p2, p3;
        logic        wr;
        logic [3:0]  nCard;
        logic [63:0] card;
        logic [3:0]  nTx;
        logic [31:0] tx;
        logic [3:0]  nRx;
        logic [31:0] rx;
        logic [7:0]  sw1, sw2;
        logic [1:0]  err;
    } vec_t;

    logic [7:0] cardQ[$];
    logic [7:0] txQ[$];
    logic [7:0] expWr[$];
    logic [7:0] expRx[$];
    int   total = 0;
    int   bad = 0;
    int   doneCnt = 0;
    logic frameErr = 1'b0;
    logic rdSeen = 1'b0;
    logic accSeen = 1'b0;
    int   pend = 0;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic failNow(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s got=%0h want=none", nm, act);
    endtask

    // Card + UART model; strobes sampled 1ns after the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!nReset) begin
                rdSeen  = 1'b0;
                accSeen = 1'b0;
                pend    = 0;
            end else begin
                if (rdSeen && cardQ.size() > 0) void'(cardQ.pop_front());
                if (accSeen && txQ.size() > 0) void'(txQ.pop_front());
                if (pend > 0) pend--;
            end
            masterStatus  = {1'b0, pend > 0, 3'b000, 1'b0, frameErr,
                             cardQ.size() > 0};
            masterDataOut = (cardQ.size() > 0) ? cardQ[0] : 8'h00;
            txValid       = txQ.size() > 0;
            txByte        = (txQ.size() > 0) ? txQ[0] : 8'h00;
            #1;
            rdSeen  = !masterNCs;
            accSeen = txValid && txReady;
            if (!masterNWe) begin
                pend = 2;
                if (expWr.size() == 0) failNow("wr_extra", masterDataIn);
                else chk("wr_byte", masterDataIn, expWr.pop_front());
            end
            if (rxValid) begin
                if (expRx.size() == 0) failNow("rx_extra", rxByte);
                else chk("rx_byte", rxByte, expRx.pop_front());
            end
            if (done) doneCnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic checkReset(input string t);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_txReady"}, txReady, 0);
        chk({t, "_rxValid"}, rxValid, 0);
        chk({t, "_nWe"}, masterNWe, 1);
        chk({t, "_nCs"}, masterNCs, 1);
        chk({t, "_dataIn"}, masterDataIn, 0);
        chk({t, "_rxByte"}, rxByte, 0);
        chk({t, "_sw1"}, sw1, 0);
        chk({t, "_sw2"}, sw2, 0);
        chk({t, "_err"}, errCode, 0);
    endtask

    task automatic issue(input logic [7:0] c, i, a, b, n, input logic w);
        @(negedge clk);
        cla = c; ins = i; p1 = a; p2 = b; p3 = n; isWrite = w;
        start = 1'b1;
        expWr.push_back(c);
        expWr.push_back(i);
        expWr.push_back(a);
        expWr.push_back(b);
        expWr.push_back(n);
    endtask

    task automatic waitDone(input string nm, input int d0, input int lim,
                            output int cyc);
        cyc = 0;
        while (doneCnt == d0 && cyc < lim) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        if (doneCnt == d0) failNow({nm, "_done_timeout"}, cyc);
    endtask

    task automatic finishCheck(input string nm, input int d0,
                               input logic [7:0] s1, s2,
                               input logic [1:0] e);
        repeat (3) @(negedge clk);
        #2;
        chk({nm, "_sw1"}, sw1, s1);
        chk({nm, "_sw2"}, sw2, s2);
        chk({nm, "_err"}, errCode, e);
        chk({nm, "_ndone"}, doneCnt - d0, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_wrLeft"}, expWr.size(), 0);
        chk({nm, "_rxLeft"}, expRx.size(), 0);
        chk({nm, "_txLeft"}, txQ.size(), 0);
        chk({nm, "_cardLeft"}, cardQ.size(), 0);
    endtask

    task automatic runVec(input vec_t v, input string nm);
        int d0, cyc;
        d0 = doneCnt;
        issue(v.cla, v.ins, v.p1, v.p2, v.p3, v.wr);
        for (int i = 0; i < int'(v.nTx); i++) begin
            expWr.push_back(v.tx[31-8*i -: 8]);
            txQ.push_back(v.tx[31-8*i -: 8]);
        end
        for (int i = 0; i < int'(v.nCard); i++)
            cardQ.push_back(v.card[63-8*i -: 8]);
        for (int i = 0; i < int'(v.nRx); i++)
            expRx.push_back(v.rx[31-8*i -: 8]);
        @(negedge clk);
        start = 1'b0;
        waitDone(nm, d0, 3000, cyc);
        finishCheck(nm, d0, v.sw1, v.sw2, v.err);
    endtask

    initial begin
        int d0, cyc, n;
        nReset = 1'b0; start = 1'b0; isWrite = 1'b0;
        cla = 0; ins = 0; p1 = 0; p2 = 0; p3 = 0;

        repeat (3) @(negedge clk);
        #2;
        checkReset("rst");
        @(negedge clk);
        nReset = 1'b1;

        vecs[0] = '{8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1,
                    4'd3, 64'h0C9000_0000000000, 4'd1, 32'h55000000,
                    4'd0, 32'h0, 8'h90, 8'h00, 2'd0};
        vecs[1] = '{8'h00, 8'hB0, 8'h00, 8'h00, 8'h02, 1'b0,
                    4'd7, 64'h6060B0AABB9000_00, 4'd0, 32'h0,
                    4'd2, 32'hAABB0000, 8'h90, 8'h00, 2'd0};
        vecs[2] = '{8'h00, 8'h0C, 8'h00, 8'h00, 8'h02, 1'b1,
                    4'd4, 64'hF3F39000_00000000, 4'd2, 32'h11220000,
                    4'd0, 32'h0, 8'h90, 8'h00, 2'd0};
        vecs[3] = '{8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1,
                    4'd1, 64'h20000000_00000000, 4'd0, 32'h0,
                    4'd0, 32'h0, 8'h00, 8'h00, 2'd2};
        vecs[4] = '{8'h00, 8'hB0, 8'h00, 8'h00, 8'h02, 1'b0,
                    4'd6, 64'h4FAA4FBB6A82_0000, 4'd0, 32'h0,
                    4'd2, 32'hAABB0000, 8'h6A, 8'h82, 2'd0};
        vecs[5] = '{8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 1'b1,
                    4'd3, 64'h0C9000_0000000000, 4'd0, 32'h0,
                    4'd0, 32'h0, 8'h90, 8'h00, 2'd0};
        vecs[6] = '{8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 1'b0,
                    4'd2, 64'h6C10_000000000000, 4'd0, 32'h0,
                    4'd0, 32'h0, 8'h6C, 8'h10, 2'd0};

        for (int k = 0; k < 7; k++)
            runVec(vecs[k], $sformatf("vec%0d", k));

        // read of P3=0 moves 256 bytes
        d0 = doneCnt;
        issue(8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 1'b0);
        cardQ.push_back(8'hB0);
        for (int i = 0; i < 256; i++) begin
            cardQ.push_back(8'(i));
            expRx.push_back(8'(i));
        end
        cardQ.push_back(8'h90);
        cardQ.push_back(8'h00);
        @(negedge clk);
        start = 1'b0;
        waitDone("rd256", d0, 5000, cyc);
        finishCheck("rd256", d0, 8'h90, 8'h00, 2'd0);

        // silent card times out; a start while busy is ignored
        d0 = doneCnt;
        issue(8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        cla = 8'hFF; ins = 8'hEE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("tmo", d0, 500, cyc);
        n = cyc + 21;
        chk("tmo_cyc_lo", n >= WWT, 1);
        chk("tmo_cyc_hi", n <= WWT + 40, 1);
        finishCheck("tmo", d0, 8'h00, 8'h00, 2'd1);

        // frame error during the receive phase
        d0 = doneCnt;
        issue(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04, 1'b0);
        cardQ.push_back(8'hB0);
        cardQ.push_back(8'hAA);
        expRx.push_back(8'hAA);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (expRx.size() > 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("ferr_rxseen", expRx.size(), 0);
        frameErr = 1'b1;
        waitDone("ferr", d0, 100, cyc);
        frameErr = 1'b0;
        finishCheck("ferr", d0, 8'h00, 8'h00, 2'd3);

        // reset in the middle of the header
        d0 = doneCnt;
        issue(8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        nReset = 1'b0;
        #2;
        checkReset("midrst");
        expWr.delete();
        cardQ.delete();
        txQ.delete();
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("midrst_nodone", doneCnt, d0);
        chk("midrst_idle", busy, 0);
        runVec(vecs[0], "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
